// File: rtl/btn_debounce_pulse_pkg.sv
// rtl/btn_debounce_pulse_pkg.sv - shared state encodings and defaults for the button debouncer
package btn_debounce_pulse_pkg;

    // Gray-style encoding: bit 1 is the debounced level in the IDLE states,
    // and exactly one bit changes on every legal transition.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } deb_state_e;

    localparam int unsigned DEB_CYCLES_DEF = 50000;
    localparam int unsigned CNT_W_DEF      = 16;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with asynchronous active-high reset
//
// Ports:
//   clk   in  1  destination clock
//   reset in  1  asynchronous, active-high; clears both flops to 0
//   d     in  1  asynchronous input
//   q     out 1  input synchronised into clk (two-cycle latency)
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// rtl/btn_debounce_pulse.sv - push-button synchroniser, debouncer and press/release pulse generator
//
// Ports:
//   clk           in  1  sole clock
//   reset         in  1  asynchronous, active-high
//   btn_in        in  1  raw bouncing button, asynchronous to clk
//   btn_level     out 1  debounced level (1 = pressed)
//   press_pulse   out 1  one-cycle pulse on an accepted 0->1 transition
//   release_pulse out 1  one-cycle pulse on an accepted 1->0 transition
//   busy          out 1  high while a transition is being qualified
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             btn_s2;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             press_d;
    logic             release_d;
    logic             btn_level_q;
    logic             busy_q;
    logic             press_q;
    logic             release_q;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE_LOW: begin
                if (btn_s2) begin
                    state_d = WAIT_HIGH;
                    cnt_clr = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (!btn_s2) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    press_d = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!btn_s2) begin
                    state_d = WAIT_LOW;
                    cnt_clr = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (btn_s2) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_LOW;
                    release_d = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE_LOW;
        endcase
    end

    // Cleared on every WAIT entry and stops at CNT_LAST because the FSM
    // leaves the WAIT state on that cycle, so it can never wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register and carry no path from btn_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_level_q <= 1'b0;
            busy_q      <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            btn_level_q <= (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
            busy_q      <= (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign busy          = busy_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule
